uart_byte_rx: RTL and testbench

UART byte receiver: the downstream partner of `uart_byte_tx`, consuming its serial `tx` line. It recovers one 8N1 frame (1 start, 8 data LSB-first, 1 stop) using 16x oversampling with majority voting. It presents the byte with a one-cycle `rx_done` strobe. The baud selection uses the same `set_baud` encoding as the transmitter, so a tx/rx pair can be looped back directly.

---
 rtl/uart_byte_rx.sv | 110 +++++++++++
 tb/tb_uart_byte_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver, 16x oversampling with 3-sample majority vote per bit.
// Baud is chosen by set_baud, latched at the start edge so a frame always decodes at one rate.
module uart_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] set_baud,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic rx_s, rx_prev_q, fall;
    logic [8:0] div_sel, div_m1_q, div_m1_d, div_q, div_d;
    logic [3:0] s_q, s_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] smp_q, smp_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic done_q, done_d, err_q, err_d;
    logic tick, decide, maj;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign fall    = rx_prev_q & ~rx_s;
    assign div_sel = set_baud == 3'd1 ? 9'd162 :
                     set_baud == 3'd2 ? 9'd80  :
                     set_baud == 3'd3 ? 9'd53  :
                     set_baud == 3'd4 ? 9'd26  : 9'd324;
    assign tick    = div_q == div_m1_q;
    assign decide  = tick && s_q == 4'd8;
    // samples at s=6,7 are stored; the s=8 sample is the live synchronized line
    assign maj     = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s) | (smp_q[0] & rx_s);

    assign data_byte = data_q;
    assign rx_done   = done_q;
    assign frame_err = err_q;
    assign busy      = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            div_m1_q  <= 9'd324;
            div_q     <= '0;
            s_q       <= '0;
            bit_q     <= '0;
            smp_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            div_m1_q  <= div_m1_d;
            div_q     <= div_d;
            s_q       <= s_d;
            bit_q     <= bit_d;
            smp_q     <= smp_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_m1_d = div_m1_q;
        div_d    = '0;
        s_d      = s_q;
        bit_d    = bit_q;
        smp_d    = smp_q;
        shift_d  = shift_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_d    = err_q;
        if (state_q == IDLE) begin
            s_d   = '0;
            bit_d = '0;
            if (fall) begin
                state_d  = START;
                div_m1_d = div_sel;
            end
        end else begin
            div_d = tick ? 9'd0 : div_q + 9'd1;
            if (tick) s_d = s_q + 4'd1;
            if (tick && (s_q == 4'd6 || s_q == 4'd7)) smp_d = {smp_q[0], rx_s};
            if (decide && state_q == START && maj) state_d = IDLE;
            if (decide && state_q == DATA) shift_d = {maj, shift_q[7:1]};
            if (decide && state_q == STOP) begin
                data_d  = shift_q;
                err_d   = ~maj;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            if (tick && s_q == 4'd15 && state_q == START) state_d = DATA;
            if (tick && s_q == 4'd15 && state_q == DATA) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = STOP;
            end
        end
    end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: bit-banged 8N1 frames against a reference of sent bytes, stop levels and baud timing.
module tb_uart_byte_rx;
    logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
    logic [2:0] set_baud = 3'd0;
    logic [7:0] data_byte;
    logic       rx_done, frame_err, busy;
    int checks = 0, errors = 0, cyc = 0, busy_cnt = 0, long_cnt = 0, t0 = 0, n0 = 0;
    logic       prev_done = 1'b0;
    logic [7:0] bq[$];
    logic       eq[$];
    int         cq[$];
    logic [7:0] rb;
    logic       rs;
    int divs[8] = '{325, 163, 81, 54, 27, 325, 325, 325};

    uart_byte_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .set_baud(set_baud), .rx(rx),
        .data_byte(data_byte), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            bq.push_back(data_byte);
            eq.push_back(frame_err);
            cq.push_back(cyc);
        end
        if (busy) busy_cnt++;
        if (rx_done && prev_done) long_cnt++;
        prev_done = rx_done;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // frame expected in clocks from pin start edge: 9.5 bits of 16 ticks plus sync and edge detect
    function automatic int frame_lat(input int div);
        return (9 * 16 + 9) * div + 3;
    endfunction

    task automatic send(input logic [7:0] b, input logic stop, input int bc, input bit chg);
        logic [9:0] f;
        logic [2:0] sb;
        f  = {stop, b, 1'b0};
        sb = set_baud;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            if (i == 0) t0 = cyc;
            if (i == 1 && chg) set_baud = 3'd0;
            repeat (bc) @(negedge clk);
        end
        rx = 1'b1;
        set_baud = sb;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] b, input logic err, input int lat);
        int k, c, l;
        k = 0;
        while (bq.size() == 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, int'(bq.size() > 0), 1);
        if (bq.size() > 0) begin
            chk({tag, "_byte"}, int'(bq.pop_front()), int'(b));
            chk({tag, "_err"}, int'(eq.pop_front()), int'(err));
            c = cq.pop_front();
            l = c - t0;
            if (lat > 0) begin
                checks++;
                assert (l >= lat - 1 && l <= lat + 1) else begin
                    errors++;
                    $error("FAIL %s_lat got %0d exp %0d+-1", tag, l, lat);
                end
            end
        end
    endtask

    task automatic glitch(input logic [2:0] b, input int lo);
        int b0, m0;
        set_baud = b;
        b0 = busy_cnt;
        m0 = bq.size();
        rx = 1'b0;
        repeat (lo) @(negedge clk);
        rx = 1'b1;
        repeat (9 * divs[b] + 20) @(negedge clk);
        chk($sformatf("glitch%0d_busy", b), busy_cnt - b0, 9 * divs[b]);
        chk($sformatf("glitch%0d_nodone", b), bq.size(), m0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_byte", int'(data_byte), 0);
        chk("rst_done", int'(rx_done), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        // single-clock low pulses: false start decided at tick 9, exposing each divider
        glitch(3'd0, 1);
        glitch(3'd1, 1);
        glitch(3'd2, 1);
        // 0F with set_baud flipped to 0 mid-frame: latched rate must hold
        set_baud = 3'd4;
        send(8'h0F, 1'b1, 16 * 27, 1'b1);
        expect_frame("b0f", 8'h0F, 1'b0, frame_lat(27));
        chk("b0f_one", bq.size(), 0);
        repeat (250) @(negedge clk);
        set_baud = 3'd3;
        send(8'hAA, 1'b1, 16 * 54, 1'b0);
        expect_frame("baa", 8'hAA, 1'b0, frame_lat(54));
        chk("baa_one", bq.size(), 0);
        repeat (250) @(negedge clk);
        set_baud = 3'd4;
        send(8'hEE, 1'b1, 16 * 27, 1'b0);
        expect_frame("bee", 8'hEE, 1'b0, frame_lat(27));
        chk("bee_one", bq.size(), 0);
        repeat (250) @(negedge clk);
        glitch(3'd4, 4 * 27);
        send(8'h55, 1'b1, 16 * 27, 1'b0);
        expect_frame("b55", 8'h55, 1'b0, frame_lat(27));
        repeat (250) @(negedge clk);
        set_baud = 3'd3;
        send(8'h3C, 1'b0, 16 * 54, 1'b0);
        expect_frame("b3c", 8'h3C, 1'b1, frame_lat(54));
        repeat (250) @(negedge clk);
        set_baud = 3'd4;
        send(8'h81, 1'b1, 16 * 27, 1'b0);
        expect_frame("b81", 8'h81, 1'b0, frame_lat(27));
        repeat (250) @(negedge clk);
        // back-to-back with the sender 3% fast: 432/1.03 ~= 419 clocks per bit
        send(8'h01, 1'b1, 419, 1'b0);
        send(8'hFE, 1'b1, 419, 1'b0);
        send(8'h7E, 1'b1, 419, 1'b0);
        expect_frame("bb1", 8'h01, 1'b0, 0);
        expect_frame("bb2", 8'hFE, 1'b0, 0);
        expect_frame("bb3", 8'h7E, 1'b0, 0);
        chk("bb_three", bq.size(), 0);
        repeat (250) @(negedge clk);
        n0 = bq.size();
        fork
            send(8'hC3, 1'b1, 16 * 27, 1'b0);
            begin
                repeat (5 * 16 * 27 + 200) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk("mid_byte", int'(data_byte), 0);
                chk("mid_done", int'(rx_done), 0);
                chk("mid_err", int'(frame_err), 0);
                chk("mid_busy", int'(busy), 0);
            end
        join
        chk("mid_nodone", bq.size(), n0);
        // the receiver may lock onto the rest of the aborted frame; let it drain
        repeat (12 * 16 * 27) @(negedge clk);
        bq.delete();
        eq.delete();
        cq.delete();
        send(8'h5A, 1'b1, 16 * 27, 1'b0);
        expect_frame("b5a", 8'h5A, 1'b0, frame_lat(27));
        repeat (250) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rb = 8'($urandom);
            rs = $urandom_range(0, 3) != 0;
            send(rb, rs, 16 * 27, 1'b0);
            expect_frame($sformatf("rnd%0d", i), rb, ~rs, frame_lat(27));
            repeat (250) @(negedge clk);
        end
        chk("one_cycle_done", long_cnt, 0);
        chk("no_stray", bq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
